// File: rtl/rv_pipe_ctrl_unit.sv
// Registered, stall-aware main decoder with RV32M mul/div occupancy tracking.
// Optional feature: define RV_ILLEGAL_TRAP_EN to add the illegal_inst output.
module rv_pipe_ctrl_unit #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   input  logic        ex_ready,
   output logic        out_valid,
   output logic [2:0]  alu_op,
   output logic [1:0]  branch,
   output logic [1:0]  mem_to_reg,
   output logic        mem_read,
   output logic        mem_write,
   output logic        alu_src,
   output logic        reg_write,
   output logic [2:0]  md_op,
   output logic        md_start,
`ifdef RV_ILLEGAL_TRAP_EN
   output logic        illegal_inst,
`endif
   output logic        md_busy
);

   typedef enum logic {ST_RUN, ST_BUSY} state_t;

   typedef struct packed {
      logic [2:0] alu_op;
      logic [1:0] branch;
      logic [1:0] mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
   } ctrl_t;

   localparam logic [CNT_W-1:0] MUL_C = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             md_start_q, md_start_d;
   logic [2:0]       md_op_q, md_op_d;
   logic             ill_q, ill_d;

   ctrl_t            dec;
   logic             dec_m;
   logic             dec_ill;
   logic [CNT_W-1:0] cyc;
   logic             accept;
   logic [4:0]       opc;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic             unused_bits;

   assign opc = inst[6:2];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];
   assign unused_bits = ^{inst[24:15], inst[11:7], inst[1:0]};

   always_comb begin
      dec     = '0;
      dec_m   = 1'b0;
      dec_ill = 1'b0;
      unique case (1'b1)
         (opc == 5'b01100): begin
            dec.alu_op    = 3'b010;
            dec.reg_write = 1'b1;
            dec_m         = (f7 == 7'b0000001);
`ifdef RV_ILLEGAL_TRAP_EN
            dec_ill = (f7 != 7'b0000000) &&
                      (f7 != 7'b0100000) &&
                      (f7 != 7'b0000001);
`endif
         end
         (opc == 5'b00000): begin
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 2'b01;
            dec.alu_src    = 1'b1;
            dec.reg_write  = 1'b1;
         end
         (opc == 5'b01000): begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         (opc == 5'b11000): begin
            dec.alu_op = 3'b001;
            dec.branch = 2'b01;
         end
         (opc == 5'b11001): begin
            dec.alu_op     = 3'b111;
            dec.branch     = 2'b10;
            dec.mem_to_reg = 2'b10;
            dec.alu_src    = 1'b1;
            dec.reg_write  = 1'b1;
         end
         (opc == 5'b11011): begin
            dec.alu_op     = 3'b110;
            dec.branch     = 2'b10;
            dec.mem_to_reg = 2'b10;
            dec.reg_write  = 1'b1;
         end
         (opc == 5'b00100): begin
            dec.alu_op    = 3'b011;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         (opc == 5'b00101): begin
            dec.alu_op     = 3'b101;
            dec.mem_to_reg = 2'b11;
            dec.alu_src    = 1'b1;
            dec.reg_write  = 1'b1;
         end
         (opc == 5'b01101): begin
            dec.alu_op    = 3'b100;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         default: begin
`ifdef RV_ILLEGAL_TRAP_EN
            dec_ill = 1'b1;
`endif
         end
      endcase
      if (dec_ill) begin
         dec   = '0;
         dec_m = 1'b0;
      end
   end

   assign cyc      = f3[2] ? DIV_C : MUL_C;
   assign in_ready = rst_n && (state_q == ST_RUN) && !flush &&
                     (!out_valid_q || ex_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      ctrl_d      = ctrl_q;
      md_start_d  = 1'b0;
      md_op_d     = md_op_q;
      ill_d       = ill_q;
      if (flush) begin
         state_d     = ST_RUN;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         ctrl_d      = '0;
         ill_d       = 1'b0;
      end else begin
         if (state_q == ST_BUSY) begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec;
            md_start_d  = dec_m;
            md_op_d     = dec_m ? f3 : 3'b000;
            ill_d       = dec_ill;
            if (dec_m && (cyc > CNT_W'(1))) begin
               state_d = ST_BUSY;
               cnt_d   = cyc - CNT_W'(1);
            end
         end else if (ex_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         ctrl_q      <= '0;
         md_start_q  <= 1'b0;
         md_op_q     <= 3'b000;
         ill_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         ctrl_q      <= ctrl_d;
         md_start_q  <= md_start_d;
         md_op_q     <= md_op_d;
         ill_q       <= ill_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign alu_op     = ctrl_q.alu_op;
   assign branch     = ctrl_q.branch;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign alu_src    = ctrl_q.alu_src;
   assign reg_write  = ctrl_q.reg_write;
   assign md_op      = md_op_q;
   assign md_start   = md_start_q;
   assign md_busy    = (state_q == ST_BUSY);
`ifdef RV_ILLEGAL_TRAP_EN
   assign illegal_inst = ill_q;
`else
   logic unused_ill;
   assign unused_ill = ill_q;
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl_unit.sv
// Scoreboard bench for rv_pipe_ctrl_unit: decode, mul/div stalls, flush, reset.
// Honours RV_ILLEGAL_TRAP_EN to check the optional illegal_inst output.
module tb_rv_pipe_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inst = '0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        ex_ready = 1'b1;
   logic        in_ready, out_valid, mem_read, mem_write;
   logic        alu_src, reg_write, md_start, md_busy;
   logic [2:0]  alu_op, md_op;
   logic [1:0]  branch, mem_to_reg;
   logic        ill_w;
   logic [16:0] obs;
   logic [16:0] sb[$];
   logic [16:0] e;
   int          checks = 0;
   int          fails = 0;

   localparam logic [31:0] I_ADD = 32'h002081B3;
   localparam logic [31:0] I_MUL = 32'h022081B3;
   localparam logic [31:0] I_DIV = 32'h0220C1B3;
   localparam logic [31:0] I_JAL = 32'h008000EF;
   localparam logic [31:0] I_ADDI = 32'h00108093;
   localparam logic [16:0] E_ADD = 17'h0A010;
   localparam logic [16:0] E_MUL = 17'h0A018;
   localparam logic [16:0] E_DIV = 17'h0A01C;
   localparam logic [16:0] E_JAL = 17'h0EA10;
   localparam logic [16:0] E_ADDI = 17'h0B030;
`ifdef RV_ILLEGAL_TRAP_EN
   localparam logic [16:0] E_UNK = 17'h18000;
   localparam logic [16:0] E_BADF7 = 17'h18000;
`else
   localparam logic [16:0] E_UNK = 17'h08000;
   localparam logic [16:0] E_BADF7 = 17'h0A010;
`endif

   always #5 clk = ~clk;

   rv_pipe_ctrl_unit dut (
      .clk(clk), .rst_n(rst_n), .inst(inst),
      .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .ex_ready(ex_ready),
      .out_valid(out_valid), .alu_op(alu_op),
      .branch(branch), .mem_to_reg(mem_to_reg),
      .mem_read(mem_read), .mem_write(mem_write),
      .alu_src(alu_src), .reg_write(reg_write),
      .md_op(md_op), .md_start(md_start),
`ifdef RV_ILLEGAL_TRAP_EN
      .illegal_inst(ill_w),
`endif
      .md_busy(md_busy)
   );

`ifndef RV_ILLEGAL_TRAP_EN
   assign ill_w = 1'b0;
`endif

   assign obs = {ill_w, out_valid, alu_op, branch, mem_to_reg,
                 mem_read, mem_write, alu_src, reg_write,
                 md_start, md_op};

   task automatic drv(input logic [31:0] i, input logic v,
                      input logic er, input logic fl);
      @(posedge clk);
      #1;
      inst = i;
      in_valid = v;
      ex_ready = er;
      flush = fl;
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== 17'h0 || in_ready !== 1'b0 || md_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold got=%h rdy=%b busy=%b exp=0",
                  obs, in_ready, md_busy);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || obs !== 17'h0) begin
         fails++;
         $display("FAIL reset_release rdy=%b got=%h exp rdy=1 obs=0",
                  in_ready, obs);
      end
   endtask

   task automatic test_decode;
      logic [31:0] ins[12];
      logic [16:0] exs[12];
      ins = '{32'h0000A083, 32'h0020A023, 32'h00208063,
              32'h000010B7, 32'h00001097, I_ADDI,
              32'h000080E7, I_JAL, I_ADD, 32'h402081B3,
              32'h0000007F, 32'hFE2081B3};
      exs = '{17'h081B0, 17'h08060, 17'h09400,
              17'h0C030, 17'h0D330, E_ADDI,
              17'h0FA30, E_JAL, E_ADD, E_ADD,
              E_UNK, E_BADF7};
      for (int i = 0; i < 12; i++) begin
         drv(ins[i], 1'b1, 1'b1, 1'b0);
         if (i > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
               fails++;
               $display("FAIL decode_%0d got=%h exp=%h", i - 1, obs, e);
            end
         end
         checks++;
         if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL decode_ready_%0d got=%b exp=1", i, in_ready);
         end else begin
            sb.push_back(exs[i]);
         end
      end
      drv(32'h0, 1'b0, 1'b1, 1'b0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL decode_11 got=%h exp=%h", obs, e);
         end
      end
      drv(32'h0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL decode_drain got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_mul;
      drv(I_MUL, 1'b1, 1'b1, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL mul_accept got=%b exp=1", in_ready);
      end else sb.push_back(E_MUL);
      drv(I_ADD, 1'b1, 1'b1, 1'b0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (obs !== e || md_busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mul_issue got=%h busy=%b rdy=%b exp=%h busy=1 rdy=0",
                     obs, md_busy, in_ready, e);
         end
      end
      drv(I_ADD, 1'b1, 1'b1, 1'b0);
      checks++;
      if (md_busy !== 1'b0 || md_start !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL mul_done busy=%b start=%b rdy=%b exp 0 0 1",
                  md_busy, md_start, in_ready);
      end else sb.push_back(E_ADD);
      drv(32'h0, 1'b0, 1'b1, 1'b0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL mul_add got=%h exp=%h", obs, e);
         end
      end
   endtask

   task automatic test_div;
      int low = 0;
      int n = 0;
      bit done = 0;
      drv(I_DIV, 1'b1, 1'b1, 1'b0);
      sb.push_back(E_DIV);
      while (!done && n < 100) begin
         drv(I_ADD, 1'b1, 1'b1, 1'b0);
         if (n == 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e || md_busy !== 1'b1) begin
               fails++;
               $display("FAIL div_issue got=%h busy=%b exp=%h busy=1",
                        obs, md_busy, e);
            end
         end
         if (in_ready === 1'b1) done = 1;
         else low++;
         n++;
      end
      checks++;
      if (!done || low != 32) begin
         fails++;
         $display("FAIL div_stall low_cycles=%0d exp=32", low);
      end
      if (done) sb.push_back(E_ADD);
      drv(32'h0, 1'b0, 1'b1, 1'b0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL div_add got=%h exp=%h", obs, e);
         end
      end
   endtask

   task automatic test_flush;
      drv(I_DIV, 1'b1, 1'b1, 1'b0);
      sb.push_back(E_DIV);
      drv(32'h0, 1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
         fails++;
         $display("FAIL flush_div got=%h exp=%h", obs, e);
      end
      repeat (4) drv(32'h0, 1'b0, 1'b1, 1'b0);
      drv(I_ADD, 1'b1, 1'b1, 1'b1);
      checks++;
      if (in_ready !== 1'b0 || md_busy !== 1'b1) begin
         fails++;
         $display("FAIL flush_block rdy=%b busy=%b exp 0 1",
                  in_ready, md_busy);
      end
      drv(32'h0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || md_busy !== 1'b0 ||
          md_start !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_abort ov=%b busy=%b st=%b rdy=%b exp 0 0 0 1",
                  out_valid, md_busy, md_start, in_ready);
      end
      drv(I_ADDI, 1'b1, 1'b1, 1'b0);
      sb.push_back(E_ADDI);
      drv(32'h0, 1'b0, 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
         fails++;
         $display("FAIL flush_pre got=%h exp=%h", obs, e);
      end
      drv(32'h0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL flush_drop got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_stall;
      drv(I_JAL, 1'b1, 1'b1, 1'b0);
      sb.push_back(E_JAL);
      for (int k = 0; k < 3; k++) begin
         drv(I_ADD, 1'b1, 1'b0, 1'b0);
         checks++;
         if (obs !== sb[0] || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_%0d got=%h rdy=%b exp=%h rdy=0",
                     k, obs, in_ready, sb[0]);
         end
      end
      drv(I_ADD, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (obs !== e || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL stall_release got=%h rdy=%b exp=%h rdy=1",
                  obs, in_ready, e);
      end else sb.push_back(E_ADD);
      drv(32'h0, 1'b0, 1'b1, 1'b0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL stall_add got=%h exp=%h", obs, e);
         end
      end
   endtask

   task automatic test_reset_mid;
      drv(I_DIV, 1'b1, 1'b1, 1'b0);
      repeat (3) drv(32'h0, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 17'h0 || md_busy !== 1'b0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid got=%h busy=%b rdy=%b exp all 0",
                  obs, md_busy, in_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || md_busy !== 1'b0 || obs !== 17'h0) begin
         fails++;
         $display("FAIL reset_mid_release rdy=%b busy=%b got=%h exp 1 0 0",
                  in_ready, md_busy, obs);
      end
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_decode();
      test_mul();
      test_div();
      test_flush();
      test_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
